// File: rtl/zero_detect_frame.sv
// zero_detect_frame: per-word zero detection, leading-zero count, a
// saturating run length of consecutive zero words, and a per-frame
// "all words were zero" result.  Every result is registered, so each
// accepted word produces its outputs one cycle after it is presented.
module zero_detect_frame #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  localparam int LZW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic             y,
  output logic [LZW-1:0]   lzc,
  output logic             frame_valid,
  output logic             frame_zero,
  output logic [CNT_W-1:0] zero_run
);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  frame_state_t   state;
  logic           acc;
  logic           is_zero;
  logic [LZW-1:0] lzc_next;
  logic           found_one;

  assign is_zero = (a == '0);

  // Leading-zero count: scan from the MSB and stop at the first set bit;
  // an all-zero word falls through with a count of WIDTH.
  always_comb begin
    lzc_next  = LZW'(WIDTH);
    found_one = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found_one && a[i]) begin
        lzc_next  = LZW'(WIDTH - 1 - i);
        found_one = 1'b1;
      end
    end
  end

  // Word-level result registers; y/lzc/zero_run only move on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= 1'b0;
      lzc       <= '0;
      zero_run  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y   <= is_zero;
        lzc <= lzc_next;
        if (!is_zero) begin
          zero_run <= '0;
        end else if (zero_run != '1) begin
          zero_run <= zero_run + 1'b1;
        end
      end
    end
  end

  // Frame tracker: acc ANDs together the zero flags of every word in the
  // current frame; the in_last word emits a one-cycle result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 1'b1;
      frame_valid <= 1'b0;
      frame_zero  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_last) begin
              frame_valid <= 1'b1;
              frame_zero  <= is_zero;
              acc         <= 1'b1;
            end else begin
              acc   <= is_zero;
              state <= IN_FRAME;
            end
          end
          IN_FRAME: begin
            if (in_last) begin
              frame_valid <= 1'b1;
              frame_zero  <= acc & is_zero;
              acc         <= 1'b1;
              state       <= IDLE;
            end else begin
              acc <= acc & is_zero;
            end
          end
          default: begin
            state <= IDLE;
            acc   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zero_detect_frame.sv
// Bench for zero_detect_frame: three instances share control inputs --
// an 8-bit word/8-bit counter instance, an 8-bit word/2-bit counter
// instance for saturation, and a 16-bit word instance for wide counts.
module tb_zero_detect_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [15:0] a16 = '0;
  logic [7:0]  a8;

  logic       ov8, y8, fv8, fz8;
  logic [3:0] lzc8;
  logic [7:0] zr8;

  logic       ovc, yc, fvc, fzc;
  logic [3:0] lzcc;
  logic [1:0] zrc;

  logic       ov16, y16, fv16, fz16;
  logic [4:0] lzc16;
  logic [7:0] zr16;

  int total = 0;
  int bad   = 0;

  assign a8 = a16[7:0];

  always #5 clk = ~clk;

  zero_detect_frame #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a8),
    .out_valid(ov8), .y(y8), .lzc(lzc8), .frame_valid(fv8),
    .frame_zero(fz8), .zero_run(zr8)
  );

  zero_detect_frame #(.WIDTH(8), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a8),
    .out_valid(ovc), .y(yc), .lzc(lzcc), .frame_valid(fvc),
    .frame_zero(fzc), .zero_run(zrc)
  );

  zero_detect_frame #(.WIDTH(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a(a16),
    .out_valid(ov16), .y(y16), .lzc(lzc16), .frame_valid(fv16),
    .frame_zero(fz16), .zero_run(zr16)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic        il;
    logic [15:0] a;
    logic        ov;
    logic        y;
    logic [3:0]  lzc;
    logic        fv;
    logic        fz;
    logic [7:0]  zr;
    logic [1:0]  zr2;
    logic [4:0]  lzc16;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[32];

  logic [1:0] m_zr2   = '0;
  logic [4:0] m_lzc16 = '0;

  // Builds one vector; the 2-bit-counter and 16-bit expectations are filled
  // in by the small reference model as the vector is applied.
  function automatic vec_t mk(input logic r, input logic iv, input logic il,
                              input logic [15:0] av, input logic ov,
                              input logic yv, input logic [3:0] lz,
                              input logic fv, input logic fz,
                              input logic [7:0] zr);
    vec_t v;
    v.rst = r;  v.iv = iv; v.il = il; v.a = av;
    v.ov = ov;  v.y = yv;  v.lzc = lz; v.fv = fv; v.fz = fz; v.zr = zr;
    v.zr2 = '0; v.lzc16 = '0;
    return v;
  endfunction

  function automatic logic [4:0] ref_lzc16(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return 5'(15 - i);
    end
    return 5'd16;
  endfunction

  task automatic check_field(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops the oldest expectation and compares it with what the DUTs show now.
  task automatic checkOutput();
    vec_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    check_field("out_valid", 8'(ov8), 8'(e.ov));
    check_field("y", 8'(y8), 8'(e.y));
    check_field("lzc", 8'(lzc8), 8'(e.lzc));
    check_field("frame_valid", 8'(fv8), 8'(e.fv));
    check_field("frame_zero", 8'(fz8), 8'(e.fz));
    check_field("zero_run", zr8, e.zr);
    check_field("zero_run_cnt2", 8'(zrc), 8'(e.zr2));
    check_field("lzc_w16", 8'(lzc16), 8'(e.lzc16));
  endtask

  // Drives one vector at the falling edge, records its expectation, and
  // checks the registered response just after the following rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    in_valid = v.iv;
    in_last  = v.il;
    a16      = v.a;
    if (v.rst) begin
      m_zr2   = '0;
      m_lzc16 = '0;
    end else if (v.iv) begin
      m_lzc16 = ref_lzc16(v.a);
      if (v.a[7:0] != 8'h00) m_zr2 = '0;
      else if (m_zr2 != 2'd3) m_zr2 = m_zr2 + 2'd1;
    end
    v.zr2   = m_zr2;
    v.lzc16 = m_lzc16;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    //            rst iv il a         ov y lzc fv fz zr
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 1);
    tbl[3]  = mk(0, 1, 1, 16'h0022, 1, 0, 2, 1, 0, 0);
    tbl[4]  = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 1);
    tbl[5]  = mk(0, 0, 0, 16'h00FF, 0, 1, 8, 0, 1, 1);
    tbl[6]  = mk(0, 1, 1, 16'h0001, 1, 0, 7, 1, 0, 0);
    tbl[7]  = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 2);
    tbl[9]  = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 3);
    tbl[10] = mk(0, 1, 1, 16'h00FF, 1, 0, 0, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 1);
    tbl[12] = mk(0, 1, 0, 16'h0022, 1, 0, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 16'h0000, 0, 0, 2, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 0, 0, 0);
    tbl[15] = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 0, 1);
    tbl[16] = mk(0, 1, 0, 16'h0022, 1, 0, 2, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 1);
    tbl[18] = mk(1, 1, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 1);
    tbl[20] = mk(0, 1, 1, 16'h0001, 1, 0, 7, 1, 0, 0);
    tbl[21] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 1);
    tbl[22] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 2);
    tbl[23] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 3);
    tbl[24] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 4);
    tbl[25] = mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0, 5);
    tbl[26] = mk(0, 1, 1, 16'h0080, 1, 0, 0, 1, 0, 0);
    tbl[27] = mk(0, 1, 1, 16'h0001, 1, 0, 7, 1, 0, 0);
    tbl[28] = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 1);
    tbl[29] = mk(0, 0, 0, 16'h0000, 0, 1, 8, 0, 1, 1);
    tbl[30] = mk(0, 1, 0, 16'h8000, 1, 1, 8, 0, 1, 2);
    tbl[31] = mk(0, 1, 1, 16'h0000, 1, 1, 8, 1, 1, 3);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i]);
    end

    // Long zero run: the 8-bit counter must stop at 255 and the 2-bit one at 3.
    applyStimulus(mk(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 258; k++) begin
      applyStimulus(mk(0, 1, 0, 16'h0000, 1, 1, 8, 0, 0,
                       (k > 255) ? 8'd255 : 8'(k)));
    end
    // A nonzero word closing the long frame clears both counters.
    applyStimulus(mk(0, 1, 1, 16'h0040, 1, 0, 1, 1, 0, 0));
    applyStimulus(mk(0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zero_detect_frame.md
ZERO_DETECT_FRAME -- requirements
Module: zero_detect_frame

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the zero-run counter, legal range 1..16.
REQ-003 The block SHALL define LZW = clog2(WIDTH+1) as the leading-zero-count width.
REQ-004 Port clk, input, 1: single clock; all logic updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: a and in_last are valid this cycle.
REQ-007 Port in_last, input, 1: the current word is the final word of a frame; qualified by in_valid.
REQ-008 Port a, input, WIDTH: data word under test.
REQ-009 Port out_valid, output, 1: y, lzc and zero_run are updated for one accepted word.
REQ-010 Port y, output, 1: the accepted word was all zeros.
REQ-011 Port lzc, output, LZW: leading-zero count of the accepted word, counted from the MSB.
REQ-012 Port frame_valid, output, 1: one-cycle pulse marking the end-of-frame result.
REQ-013 Port frame_zero, output, 1: every word of the completed frame was zero.
REQ-014 Port zero_run, output, CNT_W: count of consecutive zero words, saturating.

Function
REQ-015 The block SHALL accept a word on every cycle with in_valid=1; there is no backpressure.
REQ-016 For an accepted word, out_valid, y, lzc and zero_run SHALL update exactly 1 cycle after acceptance.
REQ-017 y SHALL be 1 iff a==0 for the accepted word.
REQ-018 lzc SHALL equal the number of leading zeros of the accepted word; lzc = WIDTH when a==0; lzc = 0 when the MSB is 1.
REQ-019 out_valid SHALL be 0 in any cycle following a cycle with in_valid=0.
REQ-020 y, lzc and zero_run SHALL hold their last values while out_valid=0.
REQ-021 zero_run SHALL increment on each accepted zero word and saturate at 2^CNT_W-1.
REQ-022 zero_run SHALL clear to 0 on each accepted nonzero word, and SHALL NOT change on idle cycles.
REQ-023 The frame FSM SHALL have two states, IDLE and IN_FRAME, plus a 1-bit accumulator acc.
REQ-024 IDLE transitions: accepted word with in_last=0 -> IN_FRAME, with acc = (a==0); accepted word with in_last=1 -> stay IDLE and emit a single-word frame result.
REQ-025 IN_FRAME transitions: accepted word with in_last=0 -> acc &= (a==0); accepted word with in_last=1 -> emit frame result = acc & (a==0), then go to IDLE.
REQ-026 Idle cycles (in_valid=0) SHALL NOT alter the FSM state or acc; frames may contain bubbles.
REQ-027 frame_valid SHALL pulse high for exactly 1 cycle, coincident with the out_valid of the in_last word.
REQ-028 frame_zero SHALL update only when frame_valid is high and SHALL hold otherwise.
REQ-029 zero_run SHALL span frame boundaries; only a nonzero word or reset clears it.
REQ-030 in_last with in_valid=0 SHALL be ignored.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set out_valid=0, y=0, lzc=0, frame_valid=0, frame_zero=0, zero_run=0, FSM=IDLE, acc=1.
REQ-032 rst SHALL take priority over a simultaneous in_valid; a word presented in a reset cycle SHALL be dropped.
REQ-033 Reset mid-frame SHALL discard the partial frame with no frame_valid pulse; the next accepted word SHALL start a new frame.

Verification (WIDTH=8 unless noted)
REQ-034 Single words a=0x00, then 0x22, then 0x00 (in_valid=1, in_last=1) -> next-cycle outputs y/lzc = 1/8, 0/2, 1/8; frame_valid=1 each cycle; frame_zero = 1, 0, 1.
REQ-035 Frame 0x00, 0x00, 0x00 with in_last on the third word -> frame_valid=1 and frame_zero=1 exactly one cycle after the third word; zero_run=3.
REQ-036 Frame 0x00, 0x22, 0x00 with a 2-cycle bubble after 0x22 -> a single frame_valid pulse with frame_zero=0; out_valid=0 during the bubble; zero_run sequence 1, 0, 1.
REQ-037 CNT_W=2, five consecutive zero words -> zero_run = 1, 2, 3, 3, 3; then 0x80 -> zero_run=0, lzc=0.
REQ-038 rst asserted after 2 words of a frame, then frame 0x01 with in_last -> no pulse from the aborted frame; one frame_valid with frame_zero=0 and lzc=7.
REQ-039 WIDTH=16, a=0x0001 then 0x0000 -> lzc = 15, then 16.
